// File: rtl/onchip_ram_pkg.sv
// rtl/onchip_ram_pkg.sv - shared types and helpers for onchip_ram_avmm
package onchip_ram_pkg;

  typedef enum logic {
    CLR  = 1'b0,
    IDLE = 1'b1
  } clr_state_e;

  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 2;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/onchip_ram_core.sv
// rtl/onchip_ram_core.sv - byte-enabled single-port RAM array with registered read
module onchip_ram_core
  import onchip_ram_pkg::*;
#(
  parameter int    DATA_W    = 32,
  parameter int    DEPTH     = 51200,
  parameter int    ADDR_W    = 16,
  parameter string INIT_FILE = "onchip_ram.hex",
  localparam int   BE_W      = DATA_W / 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  output logic [DATA_W-1:0] rdata
);

  (* ram_init_file = INIT_FILE *) logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[addr];
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/onchip_ram_avmm.sv
// rtl/onchip_ram_avmm.sv - Avalon-MM on-chip RAM slave; clear engine built with ONCHIP_RAM_CLEAR_EN
module onchip_ram_avmm
  import onchip_ram_pkg::*;
#(
  parameter int    DATA_W       = 32,
  parameter int    DEPTH        = 51200,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = "onchip_ram.hex",
  localparam int   ADDR_W       = clog2(DEPTH),
  localparam int   BE_W         = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reset_req,
  input  logic              clken,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [BE_W-1:0]   byteenable,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              readdatavalid,
  output logic              waitrequest,
  input  logic              clear_req,
  output logic              clear_busy
);

  logic en, busy, access, wr_acc, rd_acc, in_range;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we, mem_re;
  logic [BE_W-1:0]   mem_be;
  logic [DATA_W-1:0] mem_wdata, core_rdata, data1;
  logic valid1_q, valid1_d, zero1_q, zero1_d;

  assign en          = clken & ~reset_req;
  assign waitrequest = ~en | busy;
  assign access      = chipselect & (read | write) & ~waitrequest;
  assign wr_acc      = access & write;
  assign rd_acc      = access & read & ~write;
  assign in_range    = 32'(address) < 32'(DEPTH);
  assign clear_busy  = busy;

`ifdef ONCHIP_RAM_CLEAR_EN
  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLR: begin
        if (en) begin
          if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = IDLE;
          else cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE: begin
        if (clear_req) begin
          state_d = CLR;
          cnt_d   = '0;
        end
      end
      default: state_d = CLR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CLR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy     = (state_q == CLR);
  assign clr_we   = busy & en;
  assign clr_addr = cnt_q;
`else
  logic unused_clear_req;
  assign unused_clear_req = clear_req;
  assign busy     = 1'b0;
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
`endif

  // The clear engine owns the single port while busy; the bus is held off by waitrequest.
  always_comb begin
    mem_addr  = address;
    mem_we    = wr_acc & in_range;
    mem_be    = byteenable;
    mem_wdata = writedata;
    if (busy) begin
      mem_addr  = clr_addr;
      mem_we    = clr_we;
      mem_be    = '1;
      mem_wdata = '0;
    end
  end

  assign mem_re = rd_acc & in_range;

  onchip_ram_core #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .INIT_FILE(INIT_FILE)
  ) u_core (
    .clk  (clk),
    .addr (mem_addr),
    .we   (mem_we),
    .be   (mem_be),
    .wdata(mem_wdata),
    .re   (mem_re),
    .rdata(core_rdata)
  );

  // zero1 forces zero data for out-of-range reads and before the first read after reset.
  always_comb begin
    valid1_d = valid1_q;
    zero1_d  = zero1_q;
    if (en) begin
      valid1_d = rd_acc;
      if (rd_acc) zero1_d = ~in_range;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid1_q <= 1'b0;
      zero1_q  <= 1'b1;
    end else begin
      valid1_q <= valid1_d;
      zero1_q  <= zero1_d;
    end
  end

  assign data1 = zero1_q ? '0 : core_rdata;

  // readdatavalid is masked by en so a stalled pulse is seen exactly once.
  if (READ_LATENCY == READ_LATENCY_MAX) begin : g_out_reg
    logic              valid2_q, valid2_d;
    logic [DATA_W-1:0] data2_q, data2_d;

    always_comb begin
      valid2_d = valid2_q;
      data2_d  = data2_q;
      if (en) begin
        valid2_d = valid1_q;
        if (valid1_q) data2_d = data1;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        valid2_q <= 1'b0;
        data2_q  <= '0;
      end else begin
        valid2_q <= valid2_d;
        data2_q  <= data2_d;
      end
    end

    assign readdata      = data2_q;
    assign readdatavalid = valid2_q & en;
  end else begin : g_no_out_reg
    assign readdata      = data1;
    assign readdatavalid = valid1_q & en;
  end

endmodule

// File: tb/tb_onchip_ram_avmm.sv
// tb/tb_onchip_ram_avmm.sv - self-checking bench for onchip_ram_avmm at read latencies 1 and 2; honours ONCHIP_RAM_CLEAR_EN
module tb_onchip_ram_avmm;

  localparam int DEPTH  = 100;
  localparam int ADDR_W = 7;

  logic clk = 1'b0, reset = 1'b1, reset_req = 1'b0, clken = 1'b1;
  logic chipselect = 1'b0, read = 1'b0, write = 1'b0, clear_req = 1'b0;
  logic [ADDR_W-1:0] address = '0;
  logic [3:0]  byteenable = '0;
  logic [31:0] writedata = '0;
  logic [31:0] rd1, rd2;
  logic rdv1, rdv2, wr1, wr2, cb1, cb2;

  int passed = 0, total = 0, cyc = 0;
  logic wait_or = 1'b0;
  logic [31:0] mdl [DEPTH];
  logic [31:0] exp_q[$], q1[$], q2[$];
  int c1[$], c2[$];

  onchip_ram_avmm #(.DATA_W(32), .DEPTH(DEPTH), .READ_LATENCY(1), .INIT_FILE("")) u_dut1 (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken), .chipselect(chipselect),
    .read(read), .write(write), .address(address), .byteenable(byteenable), .writedata(writedata),
    .readdata(rd1), .readdatavalid(rdv1), .waitrequest(wr1), .clear_req(clear_req), .clear_busy(cb1));

  onchip_ram_avmm #(.DATA_W(32), .DEPTH(DEPTH), .READ_LATENCY(2), .INIT_FILE("")) u_dut2 (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken), .chipselect(chipselect),
    .read(read), .write(write), .address(address), .byteenable(byteenable), .writedata(writedata),
    .readdata(rd2), .readdatavalid(rdv2), .waitrequest(wr2), .clear_req(clear_req), .clear_busy(cb2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    #2;
    if (rdv1 === 1'b1) begin q1.push_back(rd1); c1.push_back(cyc); end
    if (rdv2 === 1'b1) begin q2.push_back(rd2); c2.push_back(cyc); end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // One bus command issued at a negedge; optional stall cycles with clken or reset_req dropped.
  task automatic cmd(input bit rd, input bit wr, input int addr, input logic [31:0] d,
                     input logic [3:0] be, input int stall);
    chipselect = 1'b1; read = rd; write = wr;
    address = ADDR_W'(addr); writedata = d; byteenable = be;
    for (int s = 0; s < stall; s++) begin
      if (s % 2 == 1) reset_req = 1'b1; else clken = 1'b0;
      #1;
      check1("stall_wait", wr1, 1'b1);
      @(negedge clk);
      clken = 1'b1; reset_req = 1'b0;
    end
    #1;
    wait_or = wait_or | wr1;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
    if (wr) begin
      if (addr < DEPTH)
        for (int b = 0; b < 4; b++) if (be[b]) mdl[addr][b*8 +: 8] = d[b*8 +: 8];
    end else if (rd) begin
      if (addr < DEPTH) exp_q.push_back(mdl[addr]);
      else exp_q.push_back(32'h0);
    end
  endtask

  task automatic drain(input string tag);
    repeat (5) @(negedge clk);
    check32({tag, "_cnt1"}, q1.size(), exp_q.size());
    check32({tag, "_cnt2"}, q2.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < q1.size()) check32({tag, "_d1"}, q1[i], exp_q[i]);
      if (i < q2.size()) check32({tag, "_d2"}, q2[i], exp_q[i]);
    end
    exp_q.delete(); q1.delete(); q2.delete(); c1.delete(); c2.delete();
  endtask

  task automatic count_wait(output int n);
    n = 0;
    #1;
    while (wr1 && n < 4 * DEPTH) begin
      n++;
      @(negedge clk);
      #1;
    end
    @(negedge clk);
  endtask

  initial begin
    int n, op, stall;
    logic [31:0] h1, h2, d;

    repeat (3) @(negedge clk);
    #1;
    check32("rst_rdata1", rd1, 32'h0);
    check32("rst_rdata2", rd2, 32'h0);
    check1("rst_rdv1", rdv1, 1'b0);
    check1("rst_rdv2", rdv2, 1'b0);
`ifdef ONCHIP_RAM_CLEAR_EN
    check1("rst_busy", cb1, 1'b1);
    check1("rst_wait", wr1, 1'b1);
`else
    check1("rst_busy", cb1, 1'b0);
    check1("rst_wait", wr1, 1'b0);
`endif
    @(negedge clk);
    reset = 1'b0;
`ifdef ONCHIP_RAM_CLEAR_EN
    count_wait(n);
    check32("clr_len", n, DEPTH);
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
    cmd(1, 0, DEPTH - 1, 0, 0, 0);
    cmd(1, 0, 0, 0, 0, 0);
    drain("clr_read");
`endif

    for (int i = 0; i < DEPTH; i++) cmd(0, 1, i, $urandom, 4'hF, 0);

    cmd(0, 1, 5, 32'hDEADBEEF, 4'hF, 0);
    cmd(0, 1, 5, 32'h000000AA, 4'h1, 0);
    cmd(1, 0, 5, 0, 0, 0);
    #1;
    check1("lat1_valid", rdv1, 1'b1);
    check32("lat1_data", rd1, 32'hDEADBEAA);
    check1("lat2_early", rdv2, 1'b0);
    @(negedge clk);
    #1;
    check1("lat2_valid", rdv2, 1'b1);
    check32("lat2_data", rd2, 32'hDEADBEAA);
    check1("lat1_once", rdv1, 1'b0);
    @(negedge clk);
    drain("be_merge");

    for (int i = 0; i < 3; i++) cmd(0, 1, i, $urandom, 4'hF, 0);
    wait_or = 1'b0;
    for (int i = 0; i < 3; i++) cmd(1, 0, i, 0, 0, 0);
    check1("b2b_wait", wait_or, 1'b0);
    repeat (4) @(negedge clk);
    check32("b2b_gap1a", c1[1] - c1[0], 1);
    check32("b2b_gap1b", c1[2] - c1[1], 1);
    check32("b2b_gap2a", c2[1] - c2[0], 1);
    check32("b2b_gap2b", c2[2] - c2[1], 1);
    drain("b2b");

    cmd(1, 0, 0, 0, 0, 0);
    cmd(1, 0, 1, 0, 0, 0);
    h1 = rd1; h2 = rd2;
    chipselect = 1'b1; read = 1'b1; address = ADDR_W'(2); clken = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      check32("stall_hold1", rd1, h1);
      check32("stall_hold2", rd2, h2);
      check1("stall_rdv1", rdv1, 1'b0);
      check1("stall_rdv2", rdv2, 1'b0);
      @(negedge clk);
    end
    clken = 1'b1;
    cmd(1, 0, 2, 0, 0, 0);
    cmd(1, 0, 3, 0, 0, 0);
    drain("stall");

    cmd(0, 1, DEPTH, 32'h12345678, 4'hF, 0);
    cmd(1, 0, DEPTH, 0, 0, 0);
    cmd(1, 0, DEPTH - 1, 0, 0, 0);
    cmd(1, 0, 127, 0, 0, 0);
    d = $urandom;
    cmd(1, 1, 7, d, 4'hF, 0);
    cmd(1, 0, 7, 0, 0, 0);
    drain("oor_rw");

    for (int k = 0; k < 300; k++) begin
      op    = $urandom_range(0, 9);
      stall = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
      if (op < 4)       cmd(1, 0, $urandom_range(0, 127), 0, 0, stall);
      else if (op < 8)  cmd(0, 1, $urandom_range(0, 127), $urandom, 4'($urandom), stall);
      else if (op == 8) cmd(1, 1, $urandom_range(0, 127), $urandom, 4'($urandom), stall);
      else @(negedge clk);
    end
    drain("random");

`ifdef ONCHIP_RAM_CLEAR_EN
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    n = 0;
    #1;
    while (cb1 && n < 4 * DEPTH) begin
      clear_req = (n == 10);
      n++;
      @(negedge clk);
      #1;
    end
    clear_req = 1'b0;
    @(negedge clk);
    check32("clr_req_len", n, DEPTH);
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
    cmd(1, 0, 0, 0, 0, 0);
    cmd(1, 0, 50, 0, 0, 0);
    cmd(1, 0, DEPTH - 1, 0, 0, 0);
    drain("clr_req_read");
    cmd(0, 1, 3, 32'hCAFEF00D, 4'hF, 0);
`endif

    cmd(1, 0, 3, 0, 0, 0);
    reset = 1'b1;
    void'(exp_q.pop_back());
    #1;
    check1("midrst_rdv1", rdv1, 1'b0);
    check1("midrst_rdv2", rdv2, 1'b0);
    check32("midrst_rd1", rd1, 32'h0);
    check32("midrst_rd2", rd2, 32'h0);
    @(negedge clk);
    reset = 1'b0;
`ifdef ONCHIP_RAM_CLEAR_EN
    repeat (50) @(negedge clk);
    #1;
    check1("partial_busy", cb1, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    count_wait(n);
    check32("restart_len", n, DEPTH);
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
`endif
    cmd(1, 0, 3, 0, 0, 0);
    cmd(1, 0, 4, 0, 0, 0);
    drain("post_reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
